// File: rtl/otter_csr_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : otter_csr_pkg
//  Description : Shared CSR addresses, bit positions and the interrupt
//                controller state encoding for the OTTER machine-mode
//                interrupt/CSR controller.
//  Revision    : 1.0  initial release
// ============================================================================
package otter_csr_pkg;

  // Machine-mode CSR addresses decoded by the controller
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // Implemented bit positions inside mstatus / mie / mip
  localparam int unsigned MSTATUS_MIE_BIT  = 3;
  localparam int unsigned MSTATUS_MPIE_BIT = 7;
  localparam int unsigned MEIE_BIT         = 11;

  // Interrupt controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    TRAP = 2'd2
  } int_state_t;

endpackage : otter_csr_pkg
`default_nettype wire

// File: rtl/otter_irq_edge.sv
`default_nettype none
// ============================================================================
//  Module      : otter_irq_edge
//  Description : Rising-edge detector for the external interrupt line, with
//                an optional two-flop synchronizer in front of it.
//                Macro OTTER_IRQ_SYNC_EN: when defined, the line passes
//                through two flops before edge detection.
//  Revision    : 1.0  initial release
// ============================================================================
module otter_irq_edge (
  input  logic CLK,
  input  logic RST,
  input  logic irq_i,
  output logic rise_o
);

  logic irq_s;
  logic prev_q;

`ifdef OTTER_IRQ_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-stage synchronizer for the asynchronous interrupt line
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_i;
`endif

  // Previous sample of the (possibly synchronized) line for edge detection
  always_ff @(posedge CLK) begin
    if (RST) prev_q <= 1'b0;
    else     prev_q <= irq_s;
  end

  // A held-high line produces a single rise, never a repeat
  assign rise_o = irq_s & ~prev_q;

endmodule : otter_irq_edge
`default_nettype wire

// File: rtl/otter_int_csr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : otter_int_csr_ctrl
//  Description : Machine-mode interrupt and CSR controller for the multicycle
//                OTTER core. Raises INT to the control-unit FSM, captures the
//                trap on intTaken, holds mstatus/mie/mtvec/mepc/mcause and
//                serves combinational CSR reads.
//                Macro OTTER_IRQ_SYNC_EN (in otter_irq_edge) adds a two-flop
//                synchronizer on INT_REQ.
//  Revision    : 1.0  initial release
// ============================================================================
module otter_int_csr_ctrl
  import otter_csr_pkg::*;
#(
  parameter int unsigned      XLEN        = 32,
  parameter logic [XLEN-1:0]  MTVEC_RESET = '0,
  parameter logic [XLEN-1:0]  MCAUSE_EXT  = XLEN'(32'h8000_000B)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            INT_REQ,
  input  logic            INT_TAKEN,
  input  logic            CSR_WE,
  input  logic            MRET,
  input  logic [11:0]     CSR_ADDR,
  input  logic [XLEN-1:0] CSR_WD,
  input  logic [XLEN-1:0] PC,
  output logic            INT,
  output logic [XLEN-1:0] CSR_RD,
  output logic [XLEN-1:0] MEPC,
  output logic [XLEN-1:0] MTVEC,
  output logic            MIE_O
);

  int_state_t      state_q,  state_d;
  logic            pending_q, pending_d;
  logic            mie_q,    mie_d;
  logic            mpie_q,   mpie_d;
  logic            meie_q,   meie_d;
  logic [XLEN-1:0] mtvec_q,  mtvec_d;
  logic [XLEN-1:0] mepc_q,   mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;

  logic rise;
  logic int_w;
  logic take_w;

  // PC is word aligned; its low bits never reach mepc
  logic [1:0] unused_pc_bits;
  assign unused_pc_bits = PC[1:0];

  otter_irq_edge u_irq_edge (
    .CLK    (CLK),
    .RST    (RST),
    .irq_i  (INT_REQ),
    .rise_o (rise)
  );

  // INT comes only from registers; take_w marks the single trap-entry edge
  assign int_w  = (state_q == PEND) & mie_q & meie_q;
  assign take_w = int_w & INT_TAKEN;

  // Next-state logic: a rise always lands in pending, even on the entry edge
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | rise;
    case (state_q)
      IDLE: begin
        if (rise) state_d = PEND;
      end
      PEND: begin
        if (take_w) begin
          state_d   = TRAP;
          pending_d = rise;
        end
      end
      TRAP: begin
        if (!INT_TAKEN) state_d = pending_d ? PEND : IDLE;
      end
      default: begin
        state_d   = IDLE;
        pending_d = 1'b0;
      end
    endcase
  end

  // CSR update: trap capture outranks MRET and overlapping CSR writes
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    meie_d   = meie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;

    if (CSR_WE) begin
      case (CSR_ADDR)
        CSR_MSTATUS: begin
          if (!take_w) begin
            mie_d  = CSR_WD[MSTATUS_MIE_BIT];
            mpie_d = CSR_WD[MSTATUS_MPIE_BIT];
          end
        end
        CSR_MIE:    meie_d  = CSR_WD[MEIE_BIT];
        CSR_MTVEC:  mtvec_d = {CSR_WD[XLEN-1:2], 2'b00};
        CSR_MEPC: begin
          if (!take_w) mepc_d = {CSR_WD[XLEN-1:2], 2'b00};
        end
        CSR_MCAUSE: begin
          if (!take_w) mcause_d = CSR_WD;
        end
        default: ;
      endcase
    end

    // mret restores the interrupt enable; it wins over a same-edge mstatus write
    if (MRET && !take_w) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end

    if (take_w) begin
      mepc_d   = {PC[XLEN-1:2], 2'b00};
      mcause_d = MCAUSE_EXT;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end
  end

  // State and CSR registers; reset discards any trap in progress
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      mie_q     <= 1'b0;
      mpie_q    <= 1'b0;
      meie_q    <= 1'b0;
      mtvec_q   <= MTVEC_RESET;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mie_q     <= mie_d;
      mpie_q    <= mpie_d;
      meie_q    <= meie_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      mcause_q  <= mcause_d;
    end
  end

  // Combinational CSR read mux; unmapped addresses read zero
  always_comb begin
    CSR_RD = '0;
    case (CSR_ADDR)
      CSR_MSTATUS: begin
        CSR_RD[MSTATUS_MIE_BIT]  = mie_q;
        CSR_RD[MSTATUS_MPIE_BIT] = mpie_q;
      end
      CSR_MIE:    CSR_RD[MEIE_BIT] = meie_q;
      CSR_MTVEC:  CSR_RD = mtvec_q;
      CSR_MEPC:   CSR_RD = mepc_q;
      CSR_MCAUSE: CSR_RD = mcause_q;
      CSR_MIP:    CSR_RD[MEIE_BIT] = pending_q;
      default:    CSR_RD = '0;
    endcase
  end

  assign INT   = int_w;
  assign MEPC  = mepc_q;
  assign MTVEC = mtvec_q;
  assign MIE_O = mie_q;

endmodule : otter_int_csr_ctrl
`default_nettype wire

// File: doc/otter_int_csr_ctrl.md
Name: otter_int_csr_ctrl

Overview:
Machine-mode interrupt and CSR controller for the multicycle OTTER core. It sits directly upstream of the control-unit FSM:
- Produces the INT request the FSM samples in EXECUTE/LOAD.
- Consumes the FSM's intTaken and csrWrite strobes.
- Latches and edge-detects the external interrupt line.
- Holds mstatus/mie/mtvec/mepc/mcause.
- Supplies MTVEC/MEPC to the PC mux.

Parameters:
XLEN, 32, data/address width of CSRs and PC.
MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
MCAUSE_EXT, 32'h8000_000B, value loaded into mcause on a taken external interrupt.

Ports:
CLK  in  1  core clock
RST  in  1  reset, synchronous, active-high
INT_REQ  in  1  external interrupt line, rising-edge significant
INT_TAKEN  in  1  intTaken from CU FSM
CSR_WE  in  1  csrWrite from CU FSM
MRET  in  1  decoder flag: mret executing, one-cycle pulse
CSR_ADDR  in  12  ir[31:20]
CSR_WD  in  XLEN  CSR write data
PC  in  XLEN  current PC (address of interrupted instruction)
INT  out  1  interrupt request to CU FSM
CSR_RD  out  XLEN  combinational CSR read data
MEPC  out  XLEN  mepc register
MTVEC  out  XLEN  mtvec register
MIE_O  out  1  mstatus.MIE

Behaviour:
- Reset (RST=1 at posedge CLK):
  - state=IDLE; pending=0; edge-detect previous-sample flop=0; synchronizer flops=0.
  - mstatus.MIE=0, mstatus.MPIE=0; mie.MEIE=0.
  - mtvec=MTVEC_RESET; mepc=0; mcause=0.
  - Outputs: INT=0, MEPC=0, MTVEC=MTVEC_RESET, MIE_O=0.
  - Reset mid-trap discards the trap entirely; nothing is retained.
- Edge detect:
  - irq_s is the (optionally synchronized) INT_REQ; prev is irq_s registered.
  - rise = irq_s & ~prev.
  - Level-high with no new edge does not re-pend.
- FSM states: IDLE, PEND, TRAP.
  - IDLE: on rise -> PEND (pending=1).
  - PEND: INT = mstatus.MIE & mie.MEIE, combinational from registers. On INT_TAKEN=1 with INT=1 -> TRAP, and on that same edge:
    - mepc <= {PC[XLEN-1:2],2'b00}
    - mcause <= MCAUSE_EXT
    - MPIE <= MIE, MIE <= 0
    - pending <= 0
  - TRAP: INT forced 0. Stay while INT_TAKEN=1; the FSM holds intTaken for two cycles, so only the first cycle captures. When INT_TAKEN=0 -> PEND if a rise occurred during TRAP, else IDLE.
- Spurious INT_TAKEN in IDLE, or in PEND with INT=0: ignored, no register change.
- MRET (any state): MIE <= MPIE, MPIE <= 1.
- CSR write (CSR_WE=1, any state), takes effect at next edge:
  - 0x300 mstatus: bits 3 (MIE) and 7 (MPIE) only.
  - 0x304 mie: bit 11 (MEIE).
  - 0x305 mtvec: bits [1:0] forced 0.
  - 0x341 mepc: bits [1:0] forced 0.
  - 0x342 mcause: full word.
  - 0x344 mip: read-only; write ignored.
  - Other addresses: write ignored.
- CSR read: CSR_RD is combinational from CSR_ADDR.
  - mstatus returns MIE at bit 3 and MPIE at bit 7, other bits 0.
  - mip returns pending at bit 11.
  - Unmapped addresses read 0.
- Simultaneous-event priority:
  - Trap capture beats CSR_WE to mstatus/mepc/mcause on the same edge.
  - Trap capture beats MRET.
  - rise on the trap-entry edge is recorded as pending=1 and serviced after MRET re-enables MIE.
- Latency: rise to INT is 1 edge (pending registered); INT drops the cycle after the INT_TAKEN entry edge.

Optional Feature:
Macro OTTER_IRQ_SYNC_EN.
- Defined: INT_REQ passes through a two-flop synchronizer before edge detect. pending sets on the 3rd posedge after INT_REQ is first sampled high.
- Undefined: INT_REQ feeds edge detect directly. pending sets on the 1st such posedge.
- All other behaviour is identical.

Decomposition:
Shared package otter_csr_pkg:
- CSR address localparams (CSR_MSTATUS=12'h300, CSR_MIE=12'h304, CSR_MTVEC=12'h305, CSR_MEPC=12'h341, CSR_MCAUSE=12'h342, CSR_MIP=12'h344).
- Bit indices MSTATUS_MIE_BIT=3, MSTATUS_MPIE_BIT=7, MEIE_BIT=11.
- int_state_t enum {IDLE, PEND, TRAP}.

One sub-module: otter_irq_edge, containing the optional synchronizer, prev flop and rise output.

Test Plan:
1. RST held 2 cycles, then released -> CSR_RD@0x305 = MTVEC_RESET; INT=0; MIE_O=0; MEPC=0.
2. Write mie=0x800, mstatus=0x8. Pulse INT_REQ (no sync). Next edge -> INT=1. Assert INT_TAKEN 2 cycles with PC=0x0000_0124 -> MEPC=0x124, mcause=0x8000000B, MIE_O=0, mstatus reads 0x80, INT=0.
3. After test 2, pulse MRET -> mstatus reads 0x88, MIE_O=1.
4. INT_REQ rise with MIE=0 -> mip reads 0x800 and INT=0. Then write mstatus=0x8 -> INT=1 next cycle.
5. Second INT_REQ rise during TRAP -> after INT_TAKEN falls, state PEND and INT=0 (MIE=0). MRET -> INT=1.
6. Same edge: CSR_WE to 0x341 with 0xDEAD_BEEF and trap entry with PC=0x40 -> MEPC=0x40. RST asserted in TRAP -> all CSRs at reset values, INT=0.
